// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS core control path.
// Holds opcode values, the multi-cycle FSM state encoding, and the
// aluOp / pcSrc / aluSrcB field encodings driven into the datapath.
// Both the single-cycle decoder and the multi-cycle controller import it.
package mips_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Multi-cycle FSM states; values are visible on o_state for debug.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXE_R  = 4'd6,
        S_WB_R   = 4'd7,
        S_EXE_I  = 4'd8,
        S_WB_I   = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OPC   = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALUB_RT    = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    // Immediate ALU ops that take the register-writeback I-type path
    function automatic logic is_imm_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ORI) || (op == OP_LUI);
    endfunction

    // Arithmetic immediates sign-extend; logical ones zero-extend
    function automatic logic imm_sign_ext(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ADDIU);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: watchdog for memory stalls.
// Counts cycles while enable is high; clear restarts the count at zero.
// expire fires combinationally in the cycle that enable is high and the
// count already equals MEM_TIMEOUT (i.e. after MEM_TIMEOUT tolerated waits).
// Ports: clk, rst (sync, active-high), clear, enable, expire.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [9:0] count;

    assign expire = enable && (count == 10'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 10'd1;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore sequencing FSM for the multi-cycle MIPS core.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath strobes for the current state. Memory states wait on
// i_memReady; a watchdog abandons a stall after MEM_TIMEOUT wait cycles.
// Ports: i_clk, i_rst (sync, active-high), i_opcode, i_zero, i_memReady in;
// PC/IR/memory/regfile/ALU controls, retire/illegal/memTimeout pulses and
// o_state debug out.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_memReady,
    output logic       o_pcWrite,
    output logic [1:0] o_pcSrc,
    output logic       o_irWrite,
    output logic       o_iorD,
    output logic       o_memRead,
    output logic       o_memWrite,
    output logic       o_regDst,
    output logic       o_memToReg,
    output logic       o_regWrite,
    output logic       o_extOp,
    output logic       o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [1:0] o_aluOp,
    output logic       o_retire,
    output logic       o_illegal,
    output logic       o_memTimeout,
    output logic [3:0] o_state
);

    state_t     state, state_next;
    logic [5:0] op_q;
    logic       mem_wait, wd_clear, wd_expire;

    // Watchdog runs only while a memory state is stalled. It restarts on
    // every state change and after an expiry, so a FETCH->FETCH retry
    // following a timeout starts with a fresh count.
    assign mem_wait = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR))
                      && !i_memReady;
    assign wd_clear = wd_expire || (state_next != state);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
        .clk    (i_clk),
        .rst    (i_rst),
        .clear  (wd_clear),
        .enable (mem_wait),
        .expire (wd_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) op_q <= i_opcode;
        end
    end

    always_comb begin
        state_next   = state;
        o_pcWrite    = 1'b0;
        o_pcSrc      = PCSRC_ALU;
        o_irWrite    = 1'b0;
        o_iorD       = 1'b0;
        o_memRead    = 1'b0;
        o_memWrite   = 1'b0;
        o_regDst     = 1'b0;
        o_memToReg   = 1'b0;
        o_regWrite   = 1'b0;
        o_extOp      = 1'b0;
        o_aluSrcA    = 1'b0;
        o_aluSrcB    = ALUB_RT;
        o_aluOp      = ALUOP_ADD;
        o_retire     = 1'b0;
        o_illegal    = 1'b0;
        o_memTimeout = 1'b0;
        o_state      = state;

        case (state)
            S_FETCH: begin
                o_memRead = 1'b1;
                o_aluSrcB = ALUB_FOUR;
                // Ready is checked first so it wins over a same-cycle expiry.
                if (i_memReady) begin
                    o_irWrite  = 1'b1;
                    o_pcWrite  = 1'b1;
                    state_next = S_DECODE;
                end else if (wd_expire) begin
                    o_memTimeout = 1'b1;
                    state_next   = S_FETCH;
                end
            end
            S_DECODE: begin
                o_aluSrcB = ALUB_IMMSH;  // branch target precompute
                if (i_opcode == OP_LW || i_opcode == OP_SW) state_next = S_MEMADR;
                else if (i_opcode == OP_RTYPE)              state_next = S_EXE_R;
                else if (is_imm_alu(i_opcode))              state_next = S_EXE_I;
                else if (i_opcode == OP_BEQ || i_opcode == OP_BNE) state_next = S_BRANCH;
                else if (i_opcode == OP_J)                  state_next = S_JUMP;
                else                                        state_next = S_TRAP;
            end
            S_MEMADR: begin
                o_aluSrcA  = 1'b1;
                o_aluSrcB  = ALUB_IMM;
                o_extOp    = 1'b1;
                state_next = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                o_memRead = 1'b1;
                o_iorD    = 1'b1;
                if (i_memReady) begin
                    state_next = S_MEMWB;
                end else if (wd_expire) begin
                    o_memTimeout = 1'b1;
                    state_next   = S_FETCH;
                end
            end
            S_MEMWB: begin
                o_regWrite = 1'b1;
                o_memToReg = 1'b1;
                o_retire   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                o_iorD = 1'b1;
                if (i_memReady) begin
                    o_memWrite = 1'b1;
                    o_retire   = 1'b1;
                    state_next = S_FETCH;
                end else if (wd_expire) begin
                    // Abandoned store: drop the write strobe in this cycle.
                    o_memTimeout = 1'b1;
                    state_next   = S_FETCH;
                end else begin
                    o_memWrite = 1'b1;
                end
            end
            S_EXE_R: begin
                o_aluSrcA  = 1'b1;
                o_aluOp    = ALUOP_FUNCT;
                state_next = S_WB_R;
            end
            S_WB_R: begin
                o_regWrite = 1'b1;
                o_regDst   = 1'b1;
                o_retire   = 1'b1;
                state_next = S_FETCH;
            end
            S_EXE_I: begin
                o_aluSrcA  = 1'b1;
                o_aluSrcB  = ALUB_IMM;
                o_aluOp    = ALUOP_OPC;
                o_extOp    = imm_sign_ext(op_q);
                state_next = S_WB_I;
            end
            S_WB_I: begin
                o_regWrite = 1'b1;
                o_retire   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                o_aluSrcA  = 1'b1;
                o_aluOp    = ALUOP_SUB;
                o_pcSrc    = PCSRC_BR;
                o_pcWrite  = (op_q == OP_BEQ) ? i_zero : !i_zero;
                o_retire   = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                o_pcWrite  = 1'b1;
                o_pcSrc    = PCSRC_JMP;
                o_retire   = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                o_illegal  = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase

        // Reset gates every output, including strobes of the state being left.
        if (i_rst) begin
            o_pcWrite    = 1'b0;
            o_pcSrc      = 2'b00;
            o_irWrite    = 1'b0;
            o_iorD       = 1'b0;
            o_memRead    = 1'b0;
            o_memWrite   = 1'b0;
            o_regDst     = 1'b0;
            o_memToReg   = 1'b0;
            o_regWrite   = 1'b0;
            o_extOp      = 1'b0;
            o_aluSrcA    = 1'b0;
            o_aluSrcB    = 2'b00;
            o_aluOp      = 2'b00;
            o_retire     = 1'b0;
            o_illegal    = 1'b0;
            o_memTimeout = 1'b0;
            o_state      = 4'd0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: self-checking bench for the multi-cycle controller.
// An instruction-level model expands each instruction (opcode, wait counts,
// timeouts) into its expected per-cycle output list; the bench drives the
// inputs of each cycle and compares every output at the falling edge.
module tb_mips_multicycle_ctrl;

    localparam int TO = 4;

    // State numbering as documented for o_state
    localparam int FE = 0, DE = 1, MA = 2, MR = 3, MB = 4, MW = 5;
    localparam int ER = 6, WR = 7, EI = 8, WI = 9, BR = 10, JU = 11, TR = 12;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [5:0] i_opcode;
    logic       i_zero, i_memReady;
    logic       o_pcWrite, o_irWrite, o_iorD, o_memRead, o_memWrite;
    logic       o_regDst, o_memToReg, o_regWrite, o_extOp, o_aluSrcA;
    logic       o_retire, o_illegal, o_memTimeout;
    logic [1:0] o_pcSrc, o_aluSrcB, o_aluOp;
    logic [3:0] o_state;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_zero(i_zero),
        .i_memReady(i_memReady), .o_pcWrite(o_pcWrite), .o_pcSrc(o_pcSrc),
        .o_irWrite(o_irWrite), .o_iorD(o_iorD), .o_memRead(o_memRead),
        .o_memWrite(o_memWrite), .o_regDst(o_regDst), .o_memToReg(o_memToReg),
        .o_regWrite(o_regWrite), .o_extOp(o_extOp), .o_aluSrcA(o_aluSrcA),
        .o_aluSrcB(o_aluSrcB), .o_aluOp(o_aluOp), .o_retire(o_retire),
        .o_illegal(o_illegal), .o_memTimeout(o_memTimeout), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       irw, iord, mr, mw, regdst, m2r, rw, ext, asa;
        logic [1:0] asb, aop;
        logic       ret, ill, to;
    } outs_t;

    typedef struct {
        logic       rdy;
        logic       zero;
        logic [5:0] op;
        outs_t      o;
    } vec_t;

    outs_t dut_o;
    assign dut_o = {o_state, o_pcWrite, o_pcSrc, o_irWrite, o_iorD, o_memRead,
                    o_memWrite, o_regDst, o_memToReg, o_regWrite, o_extOp,
                    o_aluSrcA, o_aluSrcB, o_aluOp, o_retire, o_illegal, o_memTimeout};

    int   tests = 0, fails = 0;
    vec_t q[$];
    vec_t tbl[4];
    int   cyc, irw_n, pcw_n, ret_n, ill_n, rw_n, mw_n, to_n, ret_cyc, to_cyc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic clr_stats();
        cyc = 0; irw_n = 0; pcw_n = 0; ret_n = 0; ill_n = 0; rw_n = 0; mw_n = 0; to_n = 0;
        ret_cyc = -1; to_cyc = -1;
    endtask

    // Drive one cycle's inputs just after the rising edge, compare at the falling edge.
    task automatic step(input vec_t v, input string name);
        i_memReady = v.rdy;
        i_zero     = v.zero;
        i_opcode   = v.op;
        @(negedge i_clk);
        cyc++;
        check($sformatf("%s cyc%0d", name, cyc), 32'(dut_o), 32'(v.o));
        irw_n += int'(o_irWrite);  pcw_n += int'(o_pcWrite);
        ill_n += int'(o_illegal);  rw_n  += int'(o_regWrite);
        mw_n  += int'(o_memWrite); ret_n += int'(o_retire);
        if (o_retire && ret_cyc < 0)     ret_cyc = cyc;
        if (o_memTimeout) begin to_n++; if (to_cyc < 0) to_cyc = cyc; end
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_q(input string name, input int n);
        for (int i = 0; i < n && q.size() > 0; i++) step(q.pop_front(), name);
        q.delete();
    endtask

    // ---------------- reference model ----------------
    // Steady outputs of each state; lop is the instruction's opcode.
    function automatic outs_t outs(input int st, input logic [5:0] lop, input logic z);
        outs_t o = '0;
        o.st = 4'(st);
        case (st)
            FE: begin o.mr = 1; o.asb = 2'b01; end
            DE: o.asb = 2'b11;
            MA: begin o.asa = 1; o.asb = 2'b10; o.ext = 1; end
            MR: begin o.mr = 1; o.iord = 1; end
            MB: begin o.rw = 1; o.m2r = 1; o.ret = 1; end
            MW: begin o.mw = 1; o.iord = 1; end
            ER: begin o.asa = 1; o.aop = 2'b10; end
            WR: begin o.rw = 1; o.regdst = 1; o.ret = 1; end
            EI: begin o.asa = 1; o.asb = 2'b10; o.aop = 2'b11;
                      o.ext = (lop == 6'h08 || lop == 6'h09); end
            WI: begin o.rw = 1; o.ret = 1; end
            BR: begin o.asa = 1; o.aop = 2'b01; o.pcsrc = 2'b01; o.ret = 1;
                      o.pcw = (lop == 6'h04) ? z : !z; end
            JU: begin o.pcw = 1; o.pcsrc = 2'b10; o.ret = 1; end
            TR: o.ill = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic vec_t mk(input int st, input logic rdy, input logic [5:0] lop, input logic z);
        vec_t v;
        v.rdy  = rdy;
        v.zero = z;
        v.op   = 6'($urandom);   // only DECODE presents the real opcode
        v.o    = outs(st, lop, z);
        return v;
    endfunction

    // A memory access: w wait cycles then a ready cycle, or (to) TO+1
    // unready cycles with the last abandoning the access.
    task automatic mem_phase(input int st, input int w, input bit to, input logic [5:0] lop,
                             output bit ok);
        vec_t v;
        int   n = to ? TO + 1 : w;
        for (int i = 0; i < n; i++) begin
            v = mk(st, 1'b0, lop, 1'($urandom));
            if (to && i == TO) begin v.o.to = 1; v.o.mw = 0; end
            q.push_back(v);
        end
        ok = !to;
        if (!to) begin
            v = mk(st, 1'b1, lop, 1'($urandom));
            if (st == FE) begin v.o.irw = 1; v.o.pcw = 1; end
            if (st == MW) v.o.ret = 1;
            q.push_back(v);
        end
    endtask

    task automatic plan(input logic [5:0] op, input int wf, input int wm,
                        input bit tof, input bit tom, input logic z);
        vec_t v;
        bit   ok;
        mem_phase(FE, wf, tof, op, ok);
        if (!ok) return;
        v = mk(DE, 1'($urandom), op, 1'($urandom));
        v.op = op;
        q.push_back(v);
        case (op)
            6'h23: begin
                q.push_back(mk(MA, 1'($urandom), op, 1'($urandom)));
                mem_phase(MR, wm, tom, op, ok);
                if (ok) q.push_back(mk(MB, 1'($urandom), op, 1'($urandom)));
            end
            6'h2B: begin
                q.push_back(mk(MA, 1'($urandom), op, 1'($urandom)));
                mem_phase(MW, wm, tom, op, ok);
            end
            6'h00: begin
                q.push_back(mk(ER, 1'($urandom), op, 1'($urandom)));
                q.push_back(mk(WR, 1'($urandom), op, 1'($urandom)));
            end
            6'h08, 6'h09, 6'h0D, 6'h0F: begin
                q.push_back(mk(EI, 1'($urandom), op, 1'($urandom)));
                q.push_back(mk(WI, 1'($urandom), op, 1'($urandom)));
            end
            6'h04, 6'h05: q.push_back(mk(BR, 1'($urandom), op, z));
            6'h02:        q.push_back(mk(JU, 1'($urandom), op, 1'($urandom)));
            default:      q.push_back(mk(TR, 1'($urandom), op, 1'($urandom)));
        endcase
    endtask

    logic [5:0] legal [10] = '{6'h00, 6'h08, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

    initial begin
        // ADDI with ready held high: FETCH, DECODE, EXE_I, WB_I.
        // EXE_I/WB_I present a junk opcode to prove the latched value is used.
        tbl[0] = '{1'b1, 1'b0, 6'h08, '{4'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                       1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0}};
        tbl[1] = '{1'b1, 1'b0, 6'h08, '{4'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                       1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0}};
        tbl[2] = '{1'b1, 1'b0, 6'h3F, '{4'd8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                       1'b0, 1'b1, 1'b1, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0}};
        tbl[3] = '{1'b1, 1'b0, 6'h3F, '{4'd9, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                       1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0}};

        i_rst = 1'b1; i_opcode = 6'h00; i_zero = 1'b0; i_memReady = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("reset_outputs", 32'(dut_o), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        clr_stats();
        for (int i = 0; i < 4; i++) step(tbl[i], "addi_tbl");
        check("addi_retire_cycle", ret_cyc, 4);
        check("addi_regwrite_cnt", rw_n, 1);

        // LW: 2 waits in FETCH, 3 in MEMRD -> retire on cycle 10
        clr_stats();
        plan(6'h23, 2, 3, 0, 0, 1'b0); run_q("lw_wait", 100);
        check("lw_retire_cycle", ret_cyc, 10);
        check("lw_irwrite_cnt", irw_n, 1);
        check("lw_pcwrite_cnt", pcw_n, 1);

        clr_stats();
        plan(6'h04, 0, 0, 0, 0, 1'b1); run_q("beq_z1", 100);
        check("beq_retire_cycle", ret_cyc, 3);
        check("beq_pcwrite_cnt", pcw_n, 2);   // fetch + taken branch
        clr_stats();
        plan(6'h05, 0, 0, 0, 0, 1'b1); run_q("bne_z1", 100);
        check("bne_retire_cycle", ret_cyc, 3);
        check("bne_pcwrite_cnt", pcw_n, 1);   // fetch only

        clr_stats();
        plan(6'h3F, 0, 0, 0, 0, 1'b0); run_q("trap", 100);
        check("trap_illegal_cnt", ill_n, 1);
        check("trap_regwrite_cnt", rw_n, 0);
        check("trap_memwrite_cnt", mw_n, 0);
        check("trap_no_retire", ret_n, 0);

        // SW stalled forever in MEMWR (entered on cycle 4): timeout on cycle 8
        clr_stats();
        plan(6'h2B, 0, 0, 0, 1, 1'b0); run_q("sw_timeout", 100);
        check("sw_timeout_cycle", to_cyc, 8);
        check("sw_timeout_no_retire", ret_n, 0);
        check("sw_timeout_cnt", to_n, 1);

        // Ready arriving exactly at the expiry count: ready wins
        clr_stats();
        plan(6'h2B, TO, TO, 0, 0, 1'b0); run_q("sw_ready_at_limit", 100);
        check("limit_no_timeout", to_n, 0);
        check("limit_retire_cnt", ret_n, 1);

        // FETCH stall abandoned, then a normal jump
        clr_stats();
        plan(6'h02, 0, 0, 1, 0, 1'b0); run_q("fetch_timeout", 100);
        check("fetch_timeout_cnt", to_n, 1);
        check("fetch_timeout_no_irw", irw_n, 0);
        plan(6'h02, 0, 0, 0, 0, 1'b0); run_q("jump", 100);

        // Reset during a MEMWR wait: outputs off in the reset cycle, FETCH after
        plan(6'h2B, 0, 3, 0, 0, 1'b0); run_q("sw_pre_reset", 5);
        i_rst = 1'b1; i_memReady = 1'b0;
        @(negedge i_clk);
        check("rst_mid_outputs", 32'(dut_o), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        plan(6'h0D, 1, 0, 0, 0, 1'b0); run_q("post_reset_ori", 100);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal[$urandom_range(0, 9)];
            plan(op, $urandom_range(0, TO), $urandom_range(0, TO),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, 1'($urandom));
            run_q("rand", 1000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
